// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
// Holds the FSM state encoding and the counter width function.
package pulse_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Width able to hold 0..w, never narrower than one bit.
  function automatic int cnt_width(input int unsigned w);
    int r;
    r = clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that holds at zero.
// Load has priority over enable; zero flags the held state.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         zero_w;

  assign zero_w = (count_q == '0);

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      load:           count_d = load_val;
      en && !zero_w:  count_d = count_q - W'(1);
      default:        count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = zero_w;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle tick into a WIDTH-cycle level.
// Optional retrigger; ignored ticks raise a one-cycle overrun.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit RETRIGGER = 1'b1,
  localparam int CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic             level,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             overrun
);

  if (WIDTH < 1 || WIDTH > 65535) begin : g_bad_width
    $error("pulse_stretcher: WIDTH must be 1..65535");
  end

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic             done_q;
  logic             done_d;
  logic             ovr_q;
  logic             ovr_d;
  logic             ld;
  logic             en;
  logic             retrig;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign retrig = tick && RETRIGGER;

  load_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (RELOAD),
    .en       (en),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tick) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!retrig && cnt_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    en     = 1'b0;
    done_d = 1'b0;
    ovr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld = tick;
      end
      ACTIVE: begin
        ld     = retrig;
        en     = !retrig;
        // A reload on the last cycle keeps the window open: no done.
        done_d = cnt_zero && !retrig;
        ovr_d  = tick && !RETRIGGER;
      end
      default: begin
        ld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  assign level     = (state_q == ACTIVE);
  assign remaining = level ? cnt : '0;
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized bench for pulse_stretcher over four configurations.
// Reference tracks each window by the cycle number it ends on.
module tb_pulse_stretcher;

  localparam int N = 4;
  localparam int WS [N] = '{4, 4, 3, 1};
  localparam bit RS [N] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic         clk;
  logic         reset;
  logic [N-1:0] tick;
  logic [N-1:0] lvl;
  logic [N-1:0] dn;
  logic [N-1:0] ov;
  logic [15:0]  rem_w [N];

  int n_chk;
  int n_fail;
  int cyc;
  int wend [N];
  bit md [N];
  bit mo [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int CW = $clog2(W + 1);
    logic [CW-1:0] rem;
    pulse_stretcher #(
      .WIDTH     (W),
      .RETRIGGER (RS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick[g]),
      .level     (lvl[g]),
      .remaining (rem),
      .done      (dn[g]),
      .overrun   (ov[g])
    );
    assign rem_w[g] = 16'(rem);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, check outputs.
  task automatic step(input logic r, input logic [N-1:0] t);
    bit act;
    int old;
    int e_lvl;
    int e_rem;
    reset = r;
    tick  = t;
    @(posedge clk);
    for (int g = 0; g < N; g++) begin
      act   = (cyc <= wend[g]);
      old   = wend[g];
      md[g] = 1'b0;
      mo[g] = 1'b0;
      if (!r) begin
        wend[g] = -100;
      end else begin
        if (t[g] && (!act || RS[g])) wend[g] = cyc + WS[g];
        else if (t[g]) mo[g] = 1'b1;
        md[g] = act && (cyc == old) && (wend[g] == old);
      end
    end
    cyc++;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      e_lvl = (cyc <= wend[g]) ? 1 : 0;
      e_rem = e_lvl ? wend[g] - cyc : 0;
      chk($sformatf("lvl%0d@%0d", g, cyc), 32'(lvl[g]), 32'(e_lvl));
      chk($sformatf("rem%0d@%0d", g, cyc), 32'(rem_w[g]), 32'(e_rem));
      chk($sformatf("done%0d@%0d", g, cyc), 32'(dn[g]), 32'(md[g]));
      chk($sformatf("ovr%0d@%0d", g, cyc), 32'(ov[g]), 32'(mo[g]));
    end
  endtask

  initial begin
    int n0;
    int n3;
    int p;
    logic [N-1:0] t;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    reset  = 1'b0;
    tick   = '0;
    for (int g = 0; g < N; g++) wend[g] = -100;

    for (int i = 0; i < 3; i++) step(1'b0, '1);
    for (int i = 0; i < 5; i++) step(1'b1, '0);

    // Single tick: count the high cycles directly as well.
    step(1'b1, '1);
    n0 = lvl[0] ? 1 : 0;
    n3 = lvl[3] ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, '0);
      n0 += lvl[0] ? 1 : 0;
      n3 += lvl[3] ? 1 : 0;
    end
    chk("w4_len", 32'(n0), 32'd4);
    chk("w1_len", 32'(n3), 32'd1);

    for (int i = 0; i < 12; i++)
      step(1'b1, (i == 0 || i == 3) ? '1 : '0);
    for (int i = 0; i < 14; i++)
      step(1'b1, (i == 0 || i == 2 || i == 5) ? '1 : '0);
    for (int i = 0; i < 21; i++) step(1'b1, '1);
    for (int i = 0; i < 8; i++) step(1'b1, '0);

    // Reset in the middle of a window, then a clean window.
    step(1'b1, '1);
    step(1'b1, '0);
    step(1'b1, '0);
    step(1'b0, '0);
    step(1'b1, '1);
    for (int i = 0; i < 10; i++) step(1'b1, '0);

    for (int i = 0; i < 3000; i++) begin
      unique case (i / 750)
        0:       p = 5;
        1:       p = 25;
        2:       p = 60;
        default: p = 95;
      endcase
      for (int g = 0; g < N; g++)
        t[g] = ($urandom_range(0, 99) < p);
      step($urandom_range(0, 63) != 0, t);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
